// File: rtl/fp_pkg.sv
// Shared types for the FP multiplier front end.
// Class codes, unpacked operand record and stage entry bundle.
package fp_pkg;

    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        SUB  = 3'd1,
        NORM = 3'd2,
        INF  = 3'd3,
        QNAN = 3'd4,
        SNAN = 3'd5
    } fp_class_e;

    typedef struct packed {
        logic                sign;
        logic [FP_EXP_W-1:0] exp;
        logic [FP_MAN_W:0]   man;
        fp_class_e           cls;
    } fp_unpacked_t;

    typedef struct packed {
        fp_unpacked_t a;
        fp_unpacked_t b;
        logic         prod_sign;
        logic         prod_nan;
        logic         prod_inf;
        logic         prod_zero;
    } fp_entry_t;

    function automatic logic is_nan(input fp_class_e c);
        return (c == QNAN) || (c == SNAN);
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational single-operand decode: sign, exponent, mantissa, class.
// FP_UNPACK_FTZ_EN flushes subnormal inputs to signed zero.
module fp_classify
    import fp_pkg::*;
#(
    parameter int  EXP_W = FP_EXP_W,
    parameter int  MAN_W = FP_MAN_W,
    parameter type unp_t = fp_unpacked_t
) (
    input  logic [EXP_W+MAN_W:0] op,
    output unp_t                 res
);

    localparam int W = 1 + EXP_W + MAN_W;

    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] f;
    logic             e_zero;
    logic             e_ones;
    logic             f_nz;

    assign e      = op[W-2 -: EXP_W];
    assign f      = op[MAN_W-1:0];
    assign e_zero = ~|e;
    assign e_ones = &e;
    assign f_nz   = |f;

    always_comb begin
        res      = '0;
        res.sign = op[W-1];
        unique case (1'b1)
            e_zero && !f_nz: begin
                res.cls = ZERO;
            end
            e_zero && f_nz: begin
`ifdef FP_UNPACK_FTZ_EN
                res.cls = ZERO;
`else
                // subnormals share the minimum normal exponent
                res.cls = SUB;
                res.exp = EXP_W'(1);
                res.man = {1'b0, f};
`endif
            end
            !e_zero && !e_ones: begin
                res.cls = NORM;
                res.exp = e;
                res.man = {1'b1, f};
            end
            e_ones && !f_nz: begin
                res.cls = INF;
                res.exp = e;
                res.man = {1'b1, {MAN_W{1'b0}}};
            end
            e_ones && f_nz: begin
                res.cls = f[MAN_W-1] ? QNAN : SNAN;
                res.exp = e;
                res.man = {1'b1, f};
            end
            default: begin
                res.cls = ZERO;
            end
        endcase
    end

endmodule

// File: rtl/fp_unpack_stage.sv
// Operand unpack stage with a 2-entry skid buffer and registered in_ready.
// FP_UNPACK_FTZ_EN (in fp_classify) flushes subnormals to zero.
module fp_unpack_stage
    import fp_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 sign_a,
    output logic                 sign_b,
    output logic [EXP_W-1:0]     exp_a,
    output logic [EXP_W-1:0]     exp_b,
    output logic [MAN_W:0]       man_a,
    output logic [MAN_W:0]       man_b,
    output logic [2:0]           cls_a,
    output logic [2:0]           cls_b,
    output logic                 prod_sign,
    output logic                 prod_nan,
    output logic                 prod_inf,
    output logic                 prod_zero
);

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W:0]   man;
        fp_class_e        cls;
    } unp_t;

    typedef struct packed {
        unp_t a;
        unp_t b;
        logic prod_sign;
        logic prod_nan;
        logic prod_inf;
        logic prod_zero;
    } entry_t;

    unp_t       dec_a;
    unp_t       dec_b;
    entry_t     new_e;
    entry_t     head;
    entry_t     tail;
    logic [1:0] count;
    logic [1:0] count_nxt;
    logic       push;
    logic       pop;

    fp_classify #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W),
        .unp_t (unp_t)
    ) u_cls_a (
        .op  (a),
        .res (dec_a)
    );

    fp_classify #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W),
        .unp_t (unp_t)
    ) u_cls_b (
        .op  (b),
        .res (dec_b)
    );

    always_comb begin
        logic nan_any;
        logic inf_any;
        logic zero_any;
        nan_any  = is_nan(dec_a.cls) || is_nan(dec_b.cls)
                || (dec_a.cls == INF && dec_b.cls == ZERO)
                || (dec_a.cls == ZERO && dec_b.cls == INF);
        inf_any  = (dec_a.cls == INF) || (dec_b.cls == INF);
        zero_any = (dec_a.cls == ZERO) || (dec_b.cls == ZERO);
        new_e           = '0;
        new_e.a         = dec_a;
        new_e.b         = dec_b;
        new_e.prod_sign = dec_a.sign ^ dec_b.sign;
        new_e.prod_nan  = nan_any;
        new_e.prod_inf  = !nan_any && inf_any;
        new_e.prod_zero = !nan_any && zero_any;
    end

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        count_nxt = count;
        unique case (1'b1)
            push && !pop: count_nxt = count + 2'd1;
            pop && !push: count_nxt = count - 2'd1;
            default:      count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count     <= 2'd0;
            head      <= '0;
            tail      <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            count     <= count_nxt;
            out_valid <= (count_nxt != 2'd0);
            in_ready  <= (count_nxt != 2'd2);
            // head is the output register; tail only fills while head stalls
            if (pop && count == 2'd2) begin
                head <= tail;
            end else if (push && (count == 2'd0 || pop)) begin
                head <= new_e;
            end else if (push) begin
                tail <= new_e;
            end
        end
    end

    assign sign_a    = head.a.sign;
    assign sign_b    = head.b.sign;
    assign exp_a     = head.a.exp;
    assign exp_b     = head.b.exp;
    assign man_a     = head.a.man;
    assign man_b     = head.b.man;
    assign cls_a     = head.a.cls;
    assign cls_b     = head.b.cls;
    assign prod_sign = head.prod_sign;
    assign prod_nan  = head.prod_nan;
    assign prod_inf  = head.prod_inf;
    assign prod_zero = head.prod_zero;

endmodule

// File: tb/tb_fp_unpack_stage.sv
// Self-checking bench for fp_unpack_stage (single precision defaults).
// Vector table, backpressure, streaming, random scoreboard and reset cases.
module tb_fp_unpack_stage;

    localparam int C_ZERO = 0;
    localparam int C_SUB  = 1;
    localparam int C_NORM = 2;
    localparam int C_INF  = 3;
    localparam int C_QNAN = 4;
    localparam int C_SNAN = 5;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic        sign_a;
    logic        sign_b;
    logic [7:0]  exp_a;
    logic [7:0]  exp_b;
    logic [23:0] man_a;
    logic [23:0] man_b;
    logic [2:0]  cls_a;
    logic [2:0]  cls_b;
    logic        prod_sign;
    logic        prod_nan;
    logic        prod_inf;
    logic        prod_zero;

    int pass_cnt;
    int total_cnt;

    fp_unpack_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sign_a    (sign_a),
        .sign_b    (sign_b),
        .exp_a     (exp_a),
        .exp_b     (exp_b),
        .man_a     (man_a),
        .man_b     (man_b),
        .cls_a     (cls_a),
        .cls_b     (cls_b),
        .prod_sign (prod_sign),
        .prod_nan  (prod_nan),
        .prod_inf  (prod_inf),
        .prod_zero (prod_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int sign;
        int exp;
        int man;
        int cls;
    } ref_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          ea;
        int          ma;
        int          ca;
        int          eb;
        int          mb;
        int          cb;
        int          psign;
        int          pnan;
        int          pinf;
        int          pzero;
    } vec_t;

    // IEEE single-precision field rules, written in plain arithmetic
    function automatic ref_t ref_dec(input logic [31:0] op);
        ref_t r;
        int   e;
        int   f;
        e      = int'(op >> 23) & 255;
        f      = int'(op) & 32'h7FFFFF;
        r.sign = int'(op >> 31) & 1;
        r.exp  = 0;
        r.man  = 0;
        r.cls  = C_ZERO;
        if (e == 0 && f == 0) begin
            r.cls = C_ZERO;
        end else if (e == 0) begin
`ifndef FP_UNPACK_FTZ_EN
            r.cls = C_SUB;
            r.exp = 1;
            r.man = f;
`endif
        end else if (e == 255 && f == 0) begin
            r.cls = C_INF;
            r.exp = 255;
            r.man = 1 << 23;
        end else if (e == 255) begin
            r.cls = (f >= (1 << 22)) ? C_QNAN : C_SNAN;
            r.exp = 255;
            r.man = f + (1 << 23);
        end else begin
            r.cls = C_NORM;
            r.exp = e;
            r.man = f + (1 << 23);
        end
        return r;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        total_cnt++;
        if (act == exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [31:0] oa,
                             input logic [31:0] ob);
        ref_t ra;
        ref_t rb;
        int   na, nb, ia, ib, za, zb, n;
        ra = ref_dec(oa);
        rb = ref_dec(ob);
        na = int'(ra.cls == C_QNAN || ra.cls == C_SNAN);
        nb = int'(rb.cls == C_QNAN || rb.cls == C_SNAN);
        ia = int'(ra.cls == C_INF);
        ib = int'(rb.cls == C_INF);
        za = int'(ra.cls == C_ZERO);
        zb = int'(rb.cls == C_ZERO);
        n  = int'(na || nb || (ia && zb) || (za && ib));
        check({tag, ".sa"}, int'(sign_a), ra.sign);
        check({tag, ".sb"}, int'(sign_b), rb.sign);
        check({tag, ".ea"}, int'(exp_a), ra.exp);
        check({tag, ".eb"}, int'(exp_b), rb.exp);
        check({tag, ".ma"}, int'(man_a), ra.man);
        check({tag, ".mb"}, int'(man_b), rb.man);
        check({tag, ".ca"}, int'(cls_a), ra.cls);
        check({tag, ".cb"}, int'(cls_b), rb.cls);
        check({tag, ".ps"}, int'(prod_sign), ra.sign ^ rb.sign);
        check({tag, ".pn"}, int'(prod_nan), n);
        check({tag, ".pi"}, int'(prod_inf), int'(!n && (ia || ib)));
        check({tag, ".pz"}, int'(prod_zero), int'(!n && (za || zb)));
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".ov"}, int'(out_valid), 0);
        check({tag, ".ir"}, int'(in_ready), 1);
        check({tag, ".data"},
              int'(|{sign_a, sign_b, exp_a, exp_b, man_a, man_b, cls_a,
                     cls_b, prod_sign, prod_nan, prod_inf, prod_zero}), 0);
    endtask

    function automatic logic [31:0] rnd_op();
        logic [7:0]  e;
        logic [22:0] f;
        case ($urandom_range(0, 5))
            0:       e = 8'h00;
            1:       e = 8'hFF;
            default: e = 8'($urandom_range(1, 254));
        endcase
        f = ($urandom_range(0, 2) == 0) ? 23'd0 : 23'($urandom);
        return {1'($urandom), e, f};
    endfunction

    function automatic logic [31:0] rnd_norm();
        return {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t        vecs[7];
    logic [63:0] q[$];
    logic [31:0] bp_a[3];
    logic [31:0] bp_b[3];

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;

        vecs[0] = '{32'h3FC00000, 32'h40000000, 8'h7F, 24'hC00000, C_NORM,
                    8'h80, 24'h800000, C_NORM, 0, 0, 0, 0};
        vecs[1] = '{32'h7F800000, 32'h80000000, 8'hFF, 24'h800000, C_INF,
                    0, 0, C_ZERO, 1, 1, 0, 0};
        vecs[2] = '{32'h7FC00000, 32'h3F800000, 8'hFF, 24'hC00000, C_QNAN,
                    8'h7F, 24'h800000, C_NORM, 0, 1, 0, 0};
`ifdef FP_UNPACK_FTZ_EN
        vecs[3] = '{32'h00000001, 32'h3F800000, 0, 0, C_ZERO,
                    8'h7F, 24'h800000, C_NORM, 0, 0, 0, 1};
`else
        vecs[3] = '{32'h00000001, 32'h3F800000, 1, 24'h000001, C_SUB,
                    8'h7F, 24'h800000, C_NORM, 0, 0, 0, 0};
`endif
        vecs[4] = '{32'h7F800001, 32'h00000000, 8'hFF, 24'h800001, C_SNAN,
                    0, 0, C_ZERO, 0, 1, 0, 0};
        vecs[5] = '{32'hFF800000, 32'h3F800000, 8'hFF, 24'h800000, C_INF,
                    8'h7F, 24'h800000, C_NORM, 1, 0, 1, 0};
        vecs[6] = '{32'h00000000, 32'hC0000000, 0, 0, C_ZERO,
                    8'h80, 24'h800000, C_NORM, 1, 0, 0, 1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        tick();
        tick();
        check_reset("rst0");
        rst_n = 1'b1;

        // directed vectors with constant expectations
        for (int i = 0; i < 7; i++) begin
            string t;
            t         = $sformatf("vec%0d", i);
            a         = vecs[i].a;
            b         = vecs[i].b;
            in_valid  = 1'b1;
            out_ready = 1'b1;
            tick();
            in_valid = 1'b0;
            check({t, ".ov"}, int'(out_valid), 1);
            check({t, ".ea"}, int'(exp_a), vecs[i].ea);
            check({t, ".ma"}, int'(man_a), vecs[i].ma);
            check({t, ".ca"}, int'(cls_a), vecs[i].ca);
            check({t, ".eb"}, int'(exp_b), vecs[i].eb);
            check({t, ".mb"}, int'(man_b), vecs[i].mb);
            check({t, ".cb"}, int'(cls_b), vecs[i].cb);
            check({t, ".ps"}, int'(prod_sign), vecs[i].psign);
            check({t, ".pn"}, int'(prod_nan), vecs[i].pnan);
            check({t, ".pi"}, int'(prod_inf), vecs[i].pinf);
            check({t, ".pz"}, int'(prod_zero), vecs[i].pzero);
            tick();
            check({t, ".drain"}, int'(out_valid), 0);
        end

        // backpressure: two fill the buffer, the third waits
        for (int i = 0; i < 3; i++) begin
            bp_a[i] = rnd_norm();
            bp_b[i] = rnd_norm();
        end
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a         = bp_a[0];
        b         = bp_b[0];
        tick();
        a = bp_a[1];
        b = bp_b[1];
        tick();
        a = bp_a[2];
        b = bp_b[2];
        check("bp.full", int'(in_ready), 0);
        tick();
        check("bp.ir", int'(in_ready), 0);
        check("bp.ov", int'(out_valid), 1);
        check_out("bp.hold0", bp_a[0], bp_b[0]);
        tick();
        check_out("bp.hold1", bp_a[0], bp_b[0]);
        out_ready = 1'b1;
        tick();
        check("bp.free", int'(in_ready), 1);
        check_out("bp.p1", bp_a[1], bp_b[1]);
        tick();
        in_valid = 1'b0;
        check("bp.ov2", int'(out_valid), 1);
        check_out("bp.p2", bp_a[2], bp_b[2]);
        tick();
        check("bp.empty", int'(out_valid), 0);

        // streaming: one transfer per cycle, no bubbles
        q.delete();
        out_ready = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) begin
                a        = rnd_norm();
                b        = rnd_norm();
                in_valid = 1'b1;
                q.push_back({a, b});
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (i < 16) begin
                logic [63:0] x;
                x = q.pop_front();
                check($sformatf("st%0d.ov", i), int'(out_valid), 1);
                check($sformatf("st%0d.ir", i), int'(in_ready), 1);
                check_out($sformatf("st%0d", i), x[63:32], x[31:0]);
            end else begin
                check("st.end", int'(out_valid), 0);
            end
        end

        // random handshakes against a FIFO scoreboard
        q.delete();
        for (int c = 0; c < 300; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            a         = rnd_op();
            b         = rnd_op();
            check("rnd.ov", int'(out_valid), int'(q.size() != 0));
            check("rnd.ir", int'(in_ready), int'(q.size() < 2));
            if (out_valid && out_ready && q.size() > 0) begin
                logic [63:0] x;
                x = q.pop_front();
                check_out("rnd", x[63:32], x[31:0]);
            end
            if (in_valid && in_ready) begin
                q.push_back({a, b});
            end
            tick();
        end

        // reset with both entries occupied
        in_valid  = 1'b1;
        out_ready = 1'b0;
        a         = 32'hC0490FDB;
        b         = 32'h7F7FFFFF;
        tick();
        tick();
        in_valid = 1'b0;
        check("rst1.full", int'(in_ready), 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_reset("rst1");
        tick();
        check("rst1.stay", int'(out_valid), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fp_unpack_stage.md
Name: fp_unpack_stage

Overview:
Parametrised, registered operand-unpack stage at the head of the FP multiplier pipeline.
- Accepts two packed IEEE-754-style operands through a valid/ready handshake.
- Splits each operand into sign, effective biased exponent and mantissa with the hidden bit restored.
- Classifies each operand (zero/subnormal/normal/inf/NaN) and pre-computes product special-case flags for downstream stages.
- A 2-entry skid buffer gives full throughput with a registered in_ready.

Parameters:
- EXP_W, 8: exponent field width.
- MAN_W, 23: stored fraction width. Operand width W = 1+EXP_W+MAN_W.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  stage can accept (registered)
- a  in  W  packed operand A: sign at MSB, exponent, then fraction
- b  in  W  packed operand B, same layout
- out_valid  out  1  unpacked pair valid
- out_ready  in  1  downstream accepts
- sign_a, sign_b  out  1  operand signs
- exp_a, exp_b  out  EXP_W  effective biased exponents
- man_a, man_b  out  MAN_W+1  mantissas, hidden bit at MSB
- cls_a, cls_b  out  3  one-hot-free class code: 0 zero, 1 subnormal, 2 normal, 3 inf, 4 qNaN, 5 sNaN
- prod_sign  out  1  sign_a XOR sign_b
- prod_nan  out  1  either operand NaN, or inf×zero
- prod_inf  out  1  not prod_nan, and either operand inf
- prod_zero  out  1  not prod_nan, and either operand zero

Behaviour:
- Reset (rst_n=0 at a clk edge): both skid entries invalid; out_valid=0; in_ready=1; all data outputs 0.
- Reset mid-transfer discards held data; no partial outputs.
- Accept when in_valid & in_ready. Data appears on outputs the next cycle: latency 1 when the buffer is empty.
- Output transfer occurs when out_valid & out_ready.
- Skid buffer, 2 entries, FIFO order:
  - in_ready = (count<2), registered.
  - count updates +1 on accept only, −1 on transfer only, unchanged on both or neither.
  - Simultaneous accept and transfer at count=2 is impossible because in_ready=0.
  - At count=1, simultaneous accept and transfer keeps count=1; the new data becomes the head next cycle.
- Output data is stable while out_valid & !out_ready. It changes only after a transfer.
- Decode, per operand: e = exponent field, f = fraction field.
  - e=0, f=0: zero; exp=0; man=0.
  - e=0, f≠0: subnormal; exp=1; man={0,f}.
  - 0<e<all-ones: normal; exp=e; man={1,f}.
  - e=all-ones, f=0: inf; exp=e; man={1,0}.
  - e=all-ones, f≠0: NaN. f MSB=1 gives qNaN, else sNaN; exp=e; man={1,f}.
- Decode is combinational on input; results are registered into the buffer entry.
- Product flags are mutually exclusive. At most one of prod_nan/prod_inf/prod_zero is 1.

Optional Feature:
FP_UNPACK_FTZ_EN
- Defined: subnormal inputs are flushed to zero. cls=zero, exp=0, man=0, sign preserved; the subnormal code is never emitted.
- Undefined: subnormals are passed as specified above.

Decomposition:
- Package fp_pkg holds:
  - EXP_W/MAN_W defaults.
  - fp_class_e enum (ZERO, SUB, NORM, INF, QNAN, SNAN).
  - Struct fp_unpacked_t (sign, exp, man, cls).
  - Struct entry type holding two fp_unpacked_t plus product flags.
- Sub-module fp_classify: combinational single-operand decode, W bits in, fp_unpacked_t out. Instantiated twice.

Test Plan:
1. a=0x3FC00000, b=0x40000000, out_ready=1 → next cycle out_valid=1; exp_a=0x7F, man_a=0xC00000, exp_b=0x80, man_b=0x800000, cls both NORM; all prod flags 0.
2. a=0x7F800000, b=0x80000000 → cls_a=INF, cls_b=ZERO, prod_nan=1, prod_sign=1; a=0x7FC00000, b=0x3F800000 → cls_a=QNAN, prod_nan=1.
3. a=0x00000001, b=0x3F800000 → without FTZ: cls_a=SUB, exp_a=1, man_a=0x000001, prod flags 0. With FP_UNPACK_FTZ_EN: cls_a=ZERO, man_a=0, prod_zero=1.
4. Backpressure: out_ready=0, drive 3 consecutive pairs → first two accepted, in_ready=0 on the third. Raise out_ready → pairs emerge in order, the third is accepted once a slot frees, and the outputs are held stable while stalled.
5. Continuous in_valid=out_ready=1 over 16 random normal pairs → one transfer per cycle, no bubbles, in order.
6. Assert rst_n=0 for one cycle with 2 entries held → next cycle out_valid=0, in_ready=1, all data outputs 0.
